pipe_out_block_buffer: RTL and testbench

- Block-aware FIFO between a 16-bit data producer (e.g. a pseudorandom or ADC-style source) and an okBTPipeOut endpoint.
- Accepts words on a valid/ready interface.
- Raises pipe_out_ready only when a full block is buffered beyond any block already being drained, so a block-throttled transfer never underruns.
- Serves pipe_out_read with one-cycle read latency.

---
 rtl/pipe_out_block_buffer.sv | 204 ++++++++++++++++++++
 tb/tb_pipe_out_block_buffer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_out_block_buffer.sv
// pipe_out_block_buffer
//
// Block-aware FIFO between a DATA_W-bit word producer and an okBTPipeOut
// endpoint. The producer writes on a valid/ready handshake. The endpoint
// sees pipe_out_ready only when a full block is buffered beyond the block
// it is currently draining. This keeps a block-throttled transfer from
// running dry. Reads have one cycle of latency.
//
// Optional statistics: define PIPE_OUT_BUF_STATS_EN to enable blocks_sent
// and max_level. When it is undefined, both ports are tied to zero.
//
// Ports
//   clk            rising-edge clock (ti_clk domain)
//   reset          asynchronous, active-high; clears all state
//   src_valid      producer has a word
//   src_data       producer word
//   src_ready      buffer accepts a word this cycle (registered)
//   pipe_out_read  endpoint read strobe
//   pipe_out_data  read word, valid the cycle after pipe_out_read
//   pipe_out_ready a full unclaimed block is buffered (registered)
//   level          current word count, 0..2^DEPTH_LOG2
//   underflow_err  sticky: a read arrived while the FIFO was empty
//   blocks_sent    completed blocks, wraps at 16 bits (stats build only)
//   max_level      highest level since reset (stats build only)
`timescale 1ns/1ps

module pipe_out_block_buffer #(
  parameter int DATA_W      = 16,
  parameter int DEPTH_LOG2  = 10,
  parameter int BLOCK_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  src_valid,
  input  logic [DATA_W-1:0]     src_data,
  output logic                  src_ready,
  input  logic                  pipe_out_read,
  output logic [DATA_W-1:0]     pipe_out_data,
  output logic                  pipe_out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  underflow_err,
  output logic [15:0]           blocks_sent,
  output logic [DEPTH_LOG2:0]   max_level
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   lvl_t;
  typedef logic [DEPTH_LOG2+1:0] sum_t;

  localparam lvl_t C_DEPTH  = lvl_t'(DEPTH);
  localparam lvl_t C_BLK_M1 = lvl_t'(BLOCK_WORDS - 1);
  localparam sum_t C_BLK    = sum_t'(BLOCK_WORDS);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  // Storage and pointers
  logic [DATA_W-1:0] r_mem [DEPTH];
  ptr_t              r_wr_ptr;
  ptr_t              r_rd_ptr;
  lvl_t              r_level;
  logic              r_src_ready;
  logic [DATA_W-1:0] r_data;
  logic              r_underflow;
  logic              r_pipe_ready;

  // Block FSM
  state_t            r_state;
  lvl_t              r_outstanding;

  // Next-state wires
  logic              w_wr;
  logic              w_rd_ok;
  lvl_t              w_level_next;
  state_t            w_state_next;
  lvl_t              w_out_next;

  assign w_wr    = src_valid && r_src_ready;
  assign w_rd_ok = pipe_out_read && (r_level != '0);

  always_comb begin
    w_level_next = r_level;
    if (w_wr && !w_rd_ok) begin
      w_level_next = r_level + lvl_t'(1);
    end else if (!w_wr && w_rd_ok) begin
      w_level_next = r_level - lvl_t'(1);
    end
  end

  // Every strobe counts toward the block, including strobes on an empty
  // FIFO. This keeps the FSM in step with the host's own block count.
  always_comb begin
    w_state_next = r_state;
    w_out_next   = r_outstanding;
    if (pipe_out_read) begin
      unique case (r_state)
        S_IDLE: begin
          if (BLOCK_WORDS == 1) begin
            w_state_next = S_IDLE;
            w_out_next   = '0;
          end else begin
            w_state_next = S_BURST;
            w_out_next   = C_BLK_M1;
          end
        end
        S_BURST: begin
          if (r_outstanding == lvl_t'(1)) begin
            w_state_next = S_IDLE;
            w_out_next   = '0;
          end else begin
            w_out_next   = r_outstanding - lvl_t'(1);
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_out_next   = '0;
        end
      endcase
    end
  end

  // Memory array has no reset, so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= src_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_src_ready   <= 1'b0;
      r_data        <= '0;
      r_underflow   <= 1'b0;
      r_pipe_ready  <= 1'b0;
      r_state       <= S_IDLE;
      r_outstanding <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + ptr_t'(1);
      end
      if (pipe_out_read) begin
        if (w_rd_ok) begin
          r_data   <= r_mem[r_rd_ptr];
          r_rd_ptr <= r_rd_ptr + ptr_t'(1);
        end else begin
          r_data      <= '0;
          r_underflow <= 1'b1;
        end
      end
      r_level       <= w_level_next;
      r_src_ready   <= (w_level_next < C_DEPTH);
      r_state       <= w_state_next;
      r_outstanding <= w_out_next;
      // Ready means "one whole block beyond what the current burst still
      // owes". So it stays high across a block boundary when enough data
      // is buffered.
      r_pipe_ready  <= (sum_t'(w_level_next) >= (C_BLK + sum_t'(w_out_next)));
    end
  end

  assign src_ready      = r_src_ready;
  assign pipe_out_data  = r_data;
  assign pipe_out_ready = r_pipe_ready;
  assign level          = r_level;
  assign underflow_err  = r_underflow;

`ifdef PIPE_OUT_BUF_STATS_EN
  logic [15:0] r_blocks_sent;
  lvl_t        r_max_level;
  logic        w_blk_done;

  assign w_blk_done = pipe_out_read &&
                      (((r_state == S_BURST) && (r_outstanding == lvl_t'(1))) ||
                       ((r_state == S_IDLE) && (BLOCK_WORDS == 1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blocks_sent <= '0;
      r_max_level   <= '0;
    end else begin
      if (w_blk_done) begin
        r_blocks_sent <= r_blocks_sent + 16'd1;
      end
      if (w_level_next > r_max_level) begin
        r_max_level <= w_level_next;
      end
    end
  end

  assign blocks_sent = r_blocks_sent;
  assign max_level   = r_max_level;
`else
  assign blocks_sent = '0;
  assign max_level   = '0;
`endif

endmodule

// File: tb/tb_pipe_out_block_buffer.sv
// Bench for pipe_out_block_buffer: directed scenarios with a read-data
// scoreboard. The stimulus pushes expected read words, and a monitor pops
// and compares them one cycle after each read strobe.
`timescale 1ns/1ps

module tb_pipe_out_block_buffer;

  logic        clk;
  logic        reset;
  logic        src_valid;
  logic [15:0] src_data;
  logic        src_ready;
  logic        pipe_out_read;
  logic [15:0] pipe_out_data;
  logic        pipe_out_ready;
  logic [10:0] level;
  logic        underflow_err;
  logic [15:0] blocks_sent;
  logic [10:0] max_level;

  pipe_out_block_buffer #(
    .DATA_W     (16),
    .DEPTH_LOG2 (10),
    .BLOCK_WORDS(256)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .src_valid     (src_valid),
    .src_data      (src_data),
    .src_ready     (src_ready),
    .pipe_out_read (pipe_out_read),
    .pipe_out_data (pipe_out_data),
    .pipe_out_ready(pipe_out_ready),
    .level         (level),
    .underflow_err (underflow_err),
    .blocks_sent   (blocks_sent),
    .max_level     (max_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [15:0] model[$];  // words the bench believes are buffered
  logic [15:0] sb[$];     // expected read data, in read order
  logic        rd_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: a read strobe at a posedge makes its data visible by the
  // following negedge.
  always @(posedge clk or posedge reset) begin
    if (reset) rd_d <= 1'b0;
    else       rd_d <= pipe_out_read;
  end

  always @(negedge clk) begin
    if (rd_d && !reset) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL sb_underrun: read data 0x%0h with no expected entry", pipe_out_data);
      end else begin
        chk("pipe_out_data", 32'(pipe_out_data), 32'(sb.pop_front()));
      end
    end
  end

  // One clock of stimulus. It is entered and left at a negedge. The model
  // handles the read before the write, because a write into an empty FIFO
  // cannot satisfy a read in the same cycle.
  task automatic cyc(input logic v, input logic [15:0] d, input logic rd);
    src_valid     = v;
    src_data      = d;
    pipe_out_read = rd;
    if (rd) begin
      if (model.size() > 0) sb.push_back(model.pop_front());
      else                  sb.push_back(16'h0000);
    end
    if (v && src_ready) model.push_back(d);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    src_valid     = 1'b0;
    src_data      = '0;
    pipe_out_read = 1'b0;
    model.delete();
    sb.delete();
    @(negedge clk);
    chk("rst_src_ready", 32'(src_ready), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_pipe_ready", 32'(pipe_out_ready), 0);
    chk("rst_data", 32'(pipe_out_data), 0);
    chk("rst_underflow", 32'(underflow_err), 0);
    chk("rst_blocks_sent", 32'(blocks_sent), 0);
    chk("rst_max_level", 32'(max_level), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_src_ready", 32'(src_ready), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    src_valid     = 1'b0;
    src_data      = '0;
    pipe_out_read = 1'b0;
    repeat (2) @(negedge clk);

    // 1: block threshold
    do_reset();
    for (int i = 0; i < 255; i++) cyc(1'b1, 16'(i), 1'b0);
    chk("t1_ready_255", 32'(pipe_out_ready), 0);
    chk("t1_level_255", 32'(level), 255);
    cyc(1'b1, 16'h00FF, 1'b0);
    chk("t1_ready_256", 32'(pipe_out_ready), 1);
    chk("t1_level_256", 32'(level), 256);
    cyc(1'b0, '0, 1'b0);

    // 2: drain one block
    cyc(1'b0, '0, 1'b1);
    chk("t2_ready_drop", 32'(pipe_out_ready), 0);
    for (int i = 1; i < 256; i++) cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    chk("t2_level", 32'(level), 0);
    chk("t2_underflow", 32'(underflow_err), 0);
    chk("t2_ready", 32'(pipe_out_ready), 0);
`ifdef PIPE_OUT_BUF_STATS_EN
    chk("t2_blocks_sent", 32'(blocks_sent), 1);
`endif

    // 3: full FIFO with src_valid held high
    do_reset();
    for (int i = 0; i < 1026; i++) cyc(1'b1, 16'(i), 1'b0);
    chk("t3_level_full", 32'(level), 1024);
    chk("t3_src_ready_full", 32'(src_ready), 0);
    cyc(1'b1, 16'hCAFE, 1'b1);
    chk("t3_level_rd", 32'(level), 1023);
    chk("t3_src_ready_rd", 32'(src_ready), 1);
    cyc(1'b1, 16'hCAFE, 1'b0);
    chk("t3_level_refill", 32'(level), 1024);
    chk("t3_src_ready_refill", 32'(src_ready), 0);
    cyc(1'b0, '0, 1'b0);
`ifdef PIPE_OUT_BUF_STATS_EN
    chk("t3_max_level", 32'(max_level), 1024);
`endif

    // 4: ready held across a block boundary
    do_reset();
    for (int i = 0; i < 600; i++) cyc(1'b1, 16'(i) ^ 16'hA5A5, 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("t4_level_600", 32'(level), 600);
    chk("t4_ready_600", 32'(pipe_out_ready), 1);
    for (int i = 0; i < 256; i++) begin
      cyc(1'b0, '0, 1'b1);
      chk("t4_ready_hold", 32'(pipe_out_ready), 1);
    end
    chk("t4_level_344", 32'(level), 344);
    for (int i = 0; i < 256; i++) cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    chk("t4_level_88", 32'(level), 88);
    chk("t4_ready_88", 32'(pipe_out_ready), 0);
`ifdef PIPE_OUT_BUF_STATS_EN
    chk("t4_max_level", 32'(max_level), 600);
    chk("t4_blocks_sent", 32'(blocks_sent), 2);
`endif

    // 5: underflow
    do_reset();
    cyc(1'b1, 16'hBEEF, 1'b0);
    cyc(1'b0, '0, 1'b1);
    chk("t5_data_beef", 32'(pipe_out_data), 32'h0000BEEF);
    cyc(1'b0, '0, 1'b1);
    chk("t5_data_zero", 32'(pipe_out_data), 0);
    chk("t5_underflow", 32'(underflow_err), 1);
    chk("t5_level", 32'(level), 0);
    repeat (3) cyc(1'b0, '0, 1'b0);
    chk("t5_underflow_sticky", 32'(underflow_err), 1);
    chk("t5_data_hold", 32'(pipe_out_data), 0);

    // 6: reset in mid-burst
    do_reset();
    for (int i = 0; i < 512; i++) cyc(1'b1, 16'(i) + 16'h3000, 1'b0);
    for (int i = 0; i < 100; i++) cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    chk("t6_level_pre", 32'(level), 412);
    do_reset();
    chk("t6_level", 32'(level), 0);
    chk("t6_pipe_ready", 32'(pipe_out_ready), 0);
    chk("t6_underflow", 32'(underflow_err), 0);
    cyc(1'b1, 16'h1234, 1'b0);
    cyc(1'b1, 16'h5678, 1'b0);
    cyc(1'b0, '0, 1'b1);
    chk("t6_first_word", 32'(pipe_out_data), 32'h00001234);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    chk("t6_level_end", 32'(level), 0);
    chk("t6_underflow_end", 32'(underflow_err), 0);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
